// File: rtl/divider_sequencer.sv
// Round-robin sequencer sharing one toggle divider between two requesters.
// Optional feature macro: SEQ_ABORT_EN (abort port cancels a run in progress).
module divider_sequencer #(
  parameter int CNT_W = 23,
  parameter int TOG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] div0,
  input  logic [CNT_W-1:0] div1,
  input  logic [TOG_W-1:0] tog0,
  input  logic [TOG_W-1:0] tog1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic             Q,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             own;      // client owning the current run
  logic             last;     // client granted most recently (round-robin pointer)
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_l;
  logic [TOG_W-1:0] tog_rem;
  logic             q_r;

  logic             win;
  logic             start;
  logic             tick;
  logic             abort_run;
  logic [CNT_W-1:0] div_sel;
  logic [TOG_W-1:0] tog_sel;

`ifdef SEQ_ABORT_EN
  assign abort_run = abort && (state == RUN);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_run    = 1'b0;
`endif

  // With both requesting, the client not granted last wins.
  always_comb begin
    win     = (req == 2'b11) ? ~last : req[1];
    div_sel = win ? div1 : div0;
    tog_sel = win ? tog1 : tog0;
    start   = (state == IDLE) && (|req);
    tick    = (state == RUN) && (cnt == div_l - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (tog_sel == '0) ? DONE : RUN;
      RUN: begin
        if (abort_run)                          state_nxt = IDLE;
        else if (tick && tog_rem == TOG_W'(1))  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider datapath; div/tog are captured only at grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_l   <= '0;
      tog_rem <= '0;
      q_r     <= 1'b0;
      own     <= 1'b0;
      last    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            own     <= win;
            last    <= win;
            div_l   <= (div_sel == '0) ? CNT_W'(1) : div_sel;
            tog_rem <= tog_sel;
            cnt     <= '0;
          end
        end
        RUN: begin
          if (abort_run) begin
            q_r <= 1'b0;
            cnt <= '0;
          end else if (tick) begin
            q_r     <= ~q_r;
            cnt     <= '0;
            tog_rem <= tog_rem - TOG_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    q_r <= 1'b0;
        default: q_r <= 1'b0;
      endcase
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    gnt    = busy ? (own ? 2'b10 : 2'b01) : 2'b00;
    done   = (state == DONE) ? gnt : 2'b00;
    locked = (state != RUN);
    Q      = q_r;
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer: arbitration, toggle timing, done, reset/abort.
module tb_divider_sequencer;

  localparam int CNT_W = 23;
  localparam int TOG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [CNT_W-1:0] div0, div1;
  logic [TOG_W-1:0] tog0, tog1;
  logic             abort;
  logic [1:0]       gnt, done;
  logic             busy, Q, locked;

  int n_chk  = 0;
  int n_pass = 0;

  divider_sequencer #(.CNT_W(CNT_W), .TOG_W(TOG_W)) dut (
    .clk(clk), .reset(reset), .req(req), .div0(div0), .div1(div1),
    .tog0(tog0), .tog1(tog1), .abort(abort), .gnt(gnt), .busy(busy),
    .done(done), .Q(Q), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".Q"}, 32'(Q), 0);
    chk({tag, ".locked"}, 32'(locked), 1);
  endtask

  // Expects client c to be granted at the next edge with the given div/tog.
  // Q after grant edge + i is (i/div)%2; DONE is seen at i == tog*div.
  task automatic run(input int c, input int dv_raw, input int tg, input bit mess);
    int dv, n, nbusy;
    logic [1:0] oh;
    dv    = (dv_raw == 0) ? 1 : dv_raw;
    n     = tg * dv;
    oh    = (c == 1) ? 2'b10 : 2'b01;
    nbusy = 0;
    step();
    chk($sformatf("c%0d.gnt", c), 32'(gnt), 32'(oh));
    for (int i = 0; i <= n; i++) begin
      if (i > 0) step();
      if (mess && i == 1) begin
        if (c == 0) begin div0 = 7; tog0 = 1; end
        else        begin div1 = 7; tog1 = 1; end
      end
      if (busy) nbusy++;
      chk($sformatf("c%0d.Q@%0d", c, i), 32'(Q), 32'((i / dv) % 2));
      if (i < n) begin
        if (done !== 2'b00 || locked !== 1'b0 || gnt !== oh)
          chk($sformatf("c%0d.run@%0d", c, i), {27'd0, done, locked, gnt}, {27'd0, 2'b00, 1'b0, oh});
      end else begin
        chk($sformatf("c%0d.done", c), 32'(done), 32'(oh));
        chk($sformatf("c%0d.lockdone", c), 32'(locked), 1);
        req[c] = 1'b0;
      end
    end
    chk($sformatf("c%0d.busylen", c), nbusy, n + 1);
    step();
    chk_idle($sformatf("c%0d.after", c));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    abort = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; abort = 1'b0;
    div0 = '0; div1 = '0; tog0 = '0; tog1 = '0;
    do_reset();
    chk_idle("reset");

    // Single client, div 3, four toggles: 13 busy cycles
    div0 = 3; tog0 = 4; req = 2'b01;
    run(0, 3, 4, 1'b0);

    // Both at once from reset: 0, then 1, then alternation resumes at 0
    do_reset();
    div0 = 2; tog0 = 2; div1 = 2; tog1 = 2; req = 2'b11;
    run(0, 2, 2, 1'b0);
    run(1, 2, 2, 1'b0);
    req = 2'b11;
    run(0, 2, 2, 1'b0);
    run(1, 2, 2, 1'b0);

    // div 0 behaves as 1; odd toggle count parks Q low at DONE exit.
    // Abort is held high: in the default build it must have no effect.
    div1 = 0; tog1 = 3; req = 2'b10;
`ifndef SEQ_ABORT_EN
    abort = 1'b1;
`endif
    run(1, 0, 3, 1'b0);
    abort = 1'b0;
    tog1 = 0; req = 2'b10;
    run(1, 0, 0, 1'b0);

    // Inputs changed mid-run do not affect the current run
    div0 = 3; tog0 = 4; req = 2'b01;
    run(0, 3, 4, 1'b1);

    // Reset mid-run: idle values, no done pulse, pointer back to client 0
    div1 = 5; tog1 = 6; req = 2'b10;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("mrst.busy_pre", 32'(busy), 1);
    reset = 1'b1; req = 2'b00;
    step();
    reset = 1'b0;
    chk_idle("mrst");
    step();
    chk("mrst.nodone", 32'(done), 0);
    div0 = 1; tog0 = 1; div1 = 1; tog1 = 1; req = 2'b11;
    run(0, 1, 1, 1'b0);
    run(1, 1, 1, 1'b0);

`ifdef SEQ_ABORT_EN
    // Abort right after the 2nd toggle; aborted client stays last-granted
    div0 = 5; tog0 = 6; req = 2'b01;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("abort.Q2", 32'(Q), 0);
    chk("abort.locked_pre", 32'(locked), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    div1 = 1; tog1 = 1; req = 2'b11;
    run(1, 1, 1, 1'b0);
    req = 2'b00;
    step();
    chk_idle("abort.end");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
